rs_branch_issue: RTL and testbench

Branch-side reservation station that feeds the single branch functional unit. It holds up to DEPTH dispatched branch/jump ops and captures missing source operands from the CDB. When the FU is free, it issues the oldest fully-ready op as a one-cycle `selected` pulse carrying both operand values. It tracks FU occupancy by observing `fu_result_valid` and flushes everything on `squash`.

---
 rtl/rs_branch_issue.sv | 158 +++++++++++++++
 tb/tb_rs_branch_issue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rs_branch_issue.sv
// Branch reservation station: holds dispatched branch ops, wakes sources from the CDB and
// issues the oldest ready op to the single branch FU. Two-source buses carry rs1 in the upper half.
module rs_branch_issue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_squash,
  input  logic                i_dispatch_valid,
  input  logic [TAG_W-1:0]    i_dispatch_rob_tag,
  input  logic [1:0]          i_dispatch_src_ready,
  input  logic [2*TAG_W-1:0]  i_dispatch_src_tag,
  input  logic [2*XLEN-1:0]   i_dispatch_src_value,
  input  logic                i_cdb_valid,
  input  logic [TAG_W-1:0]    i_cdb_tag,
  input  logic [XLEN-1:0]     i_cdb_value,
  input  logic                i_fu_result_valid,
  output logic                o_full,
  output logic                o_selected,
  output logic [TAG_W-1:0]    o_issue_rob_tag,
  output logic [2*XLEN-1:0]   o_issue_rs_value,
  output logic                o_issue_rs_value_valid,
  output logic                o_fu_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]           r_valid;
  logic [TAG_W-1:0]           r_rob_tag   [DEPTH];
  logic [1:0]                 r_src_ready [DEPTH];
  logic [1:0][TAG_W-1:0]      r_src_tag   [DEPTH];
  logic [1:0][XLEN-1:0]       r_src_value [DEPTH];
  logic [AW-1:0]              r_age       [DEPTH];
  logic                       r_full;
  logic                       r_selected;
  logic [TAG_W-1:0]           r_issue_rob_tag;
  logic [2*XLEN-1:0]          r_issue_rs_value;
  logic                       r_fu_busy;

  logic [CW-1:0]              w_count;
  logic [CW-1:0]              w_occ_next;
  logic                       w_sel_found;
  logic [AW-1:0]              w_sel_idx;
  logic [AW-1:0]              w_sel_age;
  logic [AW-1:0]              w_free_idx;
  logic                       w_fu_busy_next;
  logic                       w_issue;
  logic                       w_disp;
  logic [AW-1:0]              w_new_age;
  logic [1:0]                 w_dsp_ready;
  logic [1:0][XLEN-1:0]       w_dsp_value;

  always_comb begin
    w_count     = '0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '0;
    w_free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CW'(r_valid[i]);
      if (r_valid[i] && (&r_src_ready[i]) && (!w_sel_found || r_age[i] < w_sel_age)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = AW'(i);
        w_sel_age   = r_age[i];
      end else begin
        w_sel_found = w_sel_found;
      end
    end
    // Scan downward so the lowest free index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = AW'(i);
      end else begin
        w_free_idx = w_free_idx;
      end
    end
    w_fu_busy_next = r_fu_busy && !i_fu_result_valid;
    w_issue        = w_sel_found && !w_fu_busy_next && !i_squash;
    w_disp         = i_dispatch_valid && !r_full && !i_squash;
    w_new_age      = AW'(w_count - CW'(w_issue));
    w_occ_next     = w_count - CW'(w_issue) + CW'(w_disp);
    for (int s = 0; s < 2; s++) begin
      if (i_dispatch_src_ready[s]) begin
        w_dsp_ready[s] = 1'b1;
        w_dsp_value[s] = i_dispatch_src_value[s*XLEN +: XLEN];
      end else if (i_cdb_valid && i_dispatch_src_tag[s*TAG_W +: TAG_W] == i_cdb_tag) begin
        w_dsp_ready[s] = 1'b1;
        w_dsp_value[s] = i_cdb_value;
      end else begin
        w_dsp_ready[s] = 1'b0;
        w_dsp_value[s] = i_dispatch_src_value[s*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid          <= '0;
      r_full           <= 1'b0;
      r_selected       <= 1'b0;
      r_issue_rob_tag  <= '0;
      r_issue_rs_value <= '0;
      r_fu_busy        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rob_tag[i]   <= '0;
        r_src_ready[i] <= 2'b00;
        r_src_tag[i]   <= '0;
        r_src_value[i] <= '0;
        r_age[i]       <= '0;
      end
    end else if (i_squash) begin
      r_valid    <= '0;
      r_full     <= 1'b0;
      r_selected <= 1'b0;
      r_fu_busy  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue && w_sel_idx == AW'(i)) begin
          r_valid[i] <= 1'b0;
        end else if (r_valid[i]) begin
          if (w_issue && r_age[i] > w_sel_age) begin
            r_age[i] <= r_age[i] - AW'(1);
          end
          for (int s = 0; s < 2; s++) begin
            if (i_cdb_valid && !r_src_ready[i][s] && r_src_tag[i][s] == i_cdb_tag) begin
              r_src_ready[i][s] <= 1'b1;
              r_src_value[i][s] <= i_cdb_value;
            end
          end
        end else if (w_disp && w_free_idx == AW'(i)) begin
          r_valid[i]     <= 1'b1;
          r_rob_tag[i]   <= i_dispatch_rob_tag;
          r_src_ready[i] <= w_dsp_ready;
          r_src_tag[i]   <= i_dispatch_src_tag;
          r_src_value[i] <= w_dsp_value;
          r_age[i]       <= w_new_age;
        end
      end
      r_selected <= w_issue;
      if (w_issue) begin
        r_issue_rob_tag  <= r_rob_tag[w_sel_idx];
        r_issue_rs_value <= r_src_value[w_sel_idx];
      end
      // A same-edge issue keeps the FU busy even when a result returns.
      r_fu_busy <= w_issue || w_fu_busy_next;
      r_full    <= (w_occ_next == CW'(DEPTH));
    end
  end

  assign o_full                 = r_full;
  assign o_selected             = r_selected;
  assign o_issue_rob_tag        = r_issue_rob_tag;
  assign o_issue_rs_value       = r_issue_rs_value;
  assign o_issue_rs_value_valid = r_selected;
  assign o_fu_busy              = r_fu_busy;
endmodule

// File: tb/tb_rs_branch_issue.sv
// Bench for rs_branch_issue: directed scenarios plus random traffic, checked each cycle
// against an age-ordered queue model of the reservation station.
module tb_rs_branch_issue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset, squash, dv, cv, frv;
  logic [TAG_W-1:0] dtag, ctag;
  logic [1:0] dsr;
  logic [2*TAG_W-1:0] dst;
  logic [2*XLEN-1:0] dsv;
  logic [XLEN-1:0] cval;

  logic o_full, o_selected, o_vv, o_fu_busy;
  logic [TAG_W-1:0] o_tag;
  logic [2*XLEN-1:0] o_val;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_branch_issue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_clock(clk), .i_reset(reset), .i_squash(squash),
    .i_dispatch_valid(dv), .i_dispatch_rob_tag(dtag), .i_dispatch_src_ready(dsr),
    .i_dispatch_src_tag(dst), .i_dispatch_src_value(dsv),
    .i_cdb_valid(cv), .i_cdb_tag(ctag), .i_cdb_value(cval),
    .i_fu_result_valid(frv),
    .o_full(o_full), .o_selected(o_selected), .o_issue_rob_tag(o_tag),
    .o_issue_rs_value(o_val), .o_issue_rs_value_valid(o_vv), .o_fu_busy(o_fu_busy)
  );

  typedef struct {
    logic [TAG_W-1:0]      tag;
    logic [1:0]            rdy;
    logic [1:0][TAG_W-1:0] st;
    logic [1:0][XLEN-1:0]  v;
  } ent_t;

  ent_t q[$];
  bit m_busy, m_sel, m_full;
  logic [TAG_W-1:0] m_itag;
  logic [2*XLEN-1:0] m_ival;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: queue order is dispatch order, so the first ready element is the oldest.
  task automatic model_step();
    bit bn, disp_ok;
    int k;
    ent_t e;
    if (reset) begin
      q.delete(); m_busy = 0; m_sel = 0; m_full = 0; m_itag = '0; m_ival = '0;
      return;
    end
    if (squash) begin
      q.delete(); m_busy = 0; m_sel = 0; m_full = 0;
      return;
    end
    bn = m_busy && !frv;
    disp_ok = dv && !m_full;
    k = -1;
    if (!bn) begin
      for (int j = 0; j < q.size(); j++)
        if (k < 0 && q[j].rdy == 2'b11) k = j;
    end
    for (int j = 0; j < q.size(); j++)
      for (int s = 0; s < 2; s++)
        if (cv && !q[j].rdy[s] && q[j].st[s] == ctag) begin
          q[j].rdy[s] = 1'b1;
          q[j].v[s] = cval;
        end
    if (k >= 0) begin
      m_sel = 1; m_itag = q[k].tag; m_ival = {q[k].v[1], q[k].v[0]};
      q.delete(k); m_busy = 1;
    end else begin
      m_sel = 0; m_busy = bn;
    end
    if (disp_ok) begin
      e.tag = dtag;
      for (int s = 0; s < 2; s++) begin
        e.st[s] = dst[s*TAG_W +: TAG_W];
        if (dsr[s]) begin
          e.rdy[s] = 1'b1; e.v[s] = dsv[s*XLEN +: XLEN];
        end else if (cv && e.st[s] == ctag) begin
          e.rdy[s] = 1'b1; e.v[s] = cval;
        end else begin
          e.rdy[s] = 1'b0; e.v[s] = '0;
        end
      end
      q.push_back(e);
    end
    m_full = (q.size() == DEPTH);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("selected", o_selected, m_sel);
    chk("rs_value_valid", o_vv, m_sel);
    chk("fu_busy", o_fu_busy, m_busy);
    chk("full", o_full, m_full);
    chk("issue_rob_tag", o_tag, m_itag);
    chk("issue_rs_value", o_val, m_ival);
  endtask

  task automatic idle();
    reset = 0; squash = 0; dv = 0; cv = 0; frv = 0;
    dtag = '0; dsr = 2'b00; dst = '0; dsv = '0; ctag = '0; cval = '0;
  endtask

  task automatic disp(input logic [TAG_W-1:0] t, input logic [1:0] r,
                      input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t0,
                      input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v0);
    dv = 1; dtag = t; dsr = r; dst = {t1, t0}; dsv = {v1, v0};
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    chk("reset_full", o_full, 1'b0);
    chk("reset_busy", o_fu_busy, 1'b0);
    idle();

    // Ready dispatch issues one cycle later.
    disp(5'd3, 2'b11, 5'd0, 5'd0, 32'h10, 32'h20); step();
    idle(); step();
    chk("tp1_sel", o_selected, 1'b1);
    chk("tp1_tag", o_tag, 5'd3);
    chk("tp1_val", o_val, {32'h10, 32'h20});
    frv = 1; step(); idle();

    // rs1 waits on tag 9, woken two cycles later.
    disp(5'd5, 2'b01, 5'd9, 5'd0, 32'h0, 32'h2); step();
    idle(); step();
    cv = 1; ctag = 5'd9; cval = 32'hABCD; step();
    idle(); step();
    chk("tp2_sel", o_selected, 1'b1);
    chk("tp2_rs1", o_val[63:32], 32'hABCD);
    frv = 1; step(); idle();

    // Fill all entries with waiting ops; a fifth dispatch is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(10 + i), 2'b01, 5'(20 + i), 5'd0, 32'h0, 32'(i)); step();
    end
    chk("tp4_full", o_full, 1'b1);
    disp(5'd14, 2'b11, 5'd0, 5'd0, 32'h1, 32'h1); step();
    idle(); cv = 1; ctag = 5'd23; cval = 32'h77; step();
    idle(); step();
    chk("tp4_tag", o_tag, 5'd13);
    chk("tp4_notfull", o_full, 1'b0);

    // Squash with entries held and FU busy.
    squash = 1; step(); idle();
    chk("tp5_busy", o_fu_busy, 1'b0);
    step();

    // Same-cycle CDB bypass on dispatch.
    disp(5'd6, 2'b01, 5'd7, 5'd0, 32'h0, 32'h3); cv = 1; ctag = 5'd7; cval = 32'h55; step();
    idle(); step();
    chk("tp6_rs1", o_val[63:32], 32'h55);
    frv = 1; step(); idle();

    for (int c = 0; c < 4000; c++) begin
      reset  = (c == 2000);
      squash = ($urandom_range(0, 49) == 0);
      dv     = ($urandom_range(0, 1) == 1);
      dtag   = 5'($urandom);
      dsr    = 2'($urandom);
      dst    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      dsv    = {32'($urandom), 32'($urandom)};
      cv     = ($urandom_range(0, 2) != 0);
      ctag   = 5'($urandom_range(0, 7));
      cval   = 32'($urandom);
      frv    = ($urandom_range(0, 2) == 0);
      step();
    end
    idle(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
